ps2_key_decoder: RTL and testbench

Converts the raw PS/2 keyboard line into the 5-bit key codes consumed by the hangman datapath (letters for the word entry and guess inputs, plus Enter/Backspace control keys). It sits between the board PS/2 pins and the game control/datapath. It samples and filters the PS/2 clock and assembles 11-bit frames, checking start, parity and stop bits. It tracks break and extended prefixes, suppresses typematic auto-repeat, and presents one code per physical key press over a valid/ready handshake.

---
 rtl/hangman_kbd_pkg.sv | 55 +++++
 rtl/ps2_key_decoder_if.sv | 14 +
 rtl/ps2_frame_rx.sv | 144 ++++++++++++++
 rtl/ps2_key_decoder.sv | 151 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/hangman_kbd_pkg.sv
// Shared types, key codes and the Set-2 scancode table for the hangman keyboard path.
// Ports: none (package).
// Provides key_code_t, frame/prefix state enums and scan_to_key().
package hangman_kbd_pkg;

  typedef logic [4:0] key_code_t;

  localparam key_code_t KEY_NONE  = 5'd0;
  localparam key_code_t KEY_ENTER = 5'd27;
  localparam key_code_t KEY_BKSP  = 5'd28;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {NORM, BRK, EXT, EXTBRK} pfx_state_t;

  // Set-2 make codes for the letters plus Enter/Backspace; anything else maps to 0.
  function automatic key_code_t scan_to_key(input logic [7:0] sc);
    key_code_t k;
    case (sc)
      8'h1C: k = 5'd1;   // A
      8'h32: k = 5'd2;   // B
      8'h21: k = 5'd3;   // C
      8'h23: k = 5'd4;   // D
      8'h24: k = 5'd5;   // E
      8'h2B: k = 5'd6;   // F
      8'h34: k = 5'd7;   // G
      8'h33: k = 5'd8;   // H
      8'h43: k = 5'd9;   // I
      8'h3B: k = 5'd10;  // J
      8'h42: k = 5'd11;  // K
      8'h4B: k = 5'd12;  // L
      8'h3A: k = 5'd13;  // M
      8'h31: k = 5'd14;  // N
      8'h44: k = 5'd15;  // O
      8'h4D: k = 5'd16;  // P
      8'h15: k = 5'd17;  // Q
      8'h2D: k = 5'd18;  // R
      8'h1B: k = 5'd19;  // S
      8'h2C: k = 5'd20;  // T
      8'h3C: k = 5'd21;  // U
      8'h2A: k = 5'd22;  // V
      8'h1D: k = 5'd23;  // W
      8'h22: k = 5'd24;  // X
      8'h35: k = 5'd25;  // Y
      8'h1A: k = 5'd26;  // Z
      8'h5A: k = KEY_ENTER;
      8'h66: k = KEY_BKSP;
      default: k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key-code handshake between the PS/2 decoder and the game control/datapath.
// Ports: key_valid, key_code (producer -> consumer), key_ready (consumer -> producer).
// master = decoder side, slave = consumer side.
interface ps2_key_decoder_if;
  import hangman_kbd_pkg::*;

  logic      key_valid;
  key_code_t key_code;
  logic      key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes and filters the pins, assembles 11-bit frames.
// Latency: byte_stb one cycle after the stop-bit fall_stb; fall_stb lags the pin by 2+FILTER_LEN.
// Backpressure: none; byte_stb, frame_err and timeout are single-cycle pulses.
// Ports: clk, resetn, ps2_clk, ps2_dat in; byte_stb, rx_byte, frame_err, timeout out.
module ps2_frame_rx
  import hangman_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_stb,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       timeout
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          fall_stb;

  // Idle PS/2 lines are high, so synchronizers and filter reset to 1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered level flips after FILTER_LEN consecutive samples that disagree with it;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
      fall_stb <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (clk_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
        fall_stb <= filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic          stb_n, err_n, tmo_n;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tmo_cnt   <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par       <= par_n;
      tmo_cnt   <= tmo_cnt_n;
      byte_stb  <= stb_n;
      frame_err <= err_n;
      timeout   <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    stb_n     = 1'b0;
    err_n     = 1'b0;
    tmo_n     = 1'b0;
    // Counts cycles since the last falling edge while a frame is open.
    if (state == IDLE || fall_stb) tmo_cnt_n = '0;
    else                           tmo_cnt_n = tmo_cnt + TW'(1);

    if (fall_stb) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            err_n = 1'b1;
          end
        end
        DATA: begin
          shreg_n   = {dat_s2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s2;
          state_n = STOP;
        end
        STOP: begin
          if (dat_s2 && (^{shreg, par})) stb_n = 1'b1;
          else                           err_n = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      state_n = IDLE;
      err_n   = 1'b1;
      tmo_n   = 1'b1;
    end
  end

  // Shift register is untouched between the stop bit and the next data bit.
  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to hangman key codes: prefix tracking, auto-repeat suppression, output buffer.
// Latency: key_valid 2 cycles after the stop-bit fall_stb.
// Backpressure: key_ready stalls the buffer; a key arriving at a full buffer is dropped with overflow.
// Ports: clk, resetn, ps2_clk, ps2_dat in; key (master: key_valid/key_code out, key_ready in);
//        frame_err, overflow out. Macro KEY_FIFO_EN swaps the holding register for a 4-entry FIFO.
module ps2_key_decoder
  import hangman_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  ps2_key_decoder_if.master  key,
  output logic               frame_err,
  output logic               overflow
);

  logic       byte_stb, rx_err, rx_timeout;
  logic [7:0] rx_byte;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .byte_stb (byte_stb),
    .rx_byte  (rx_byte),
    .frame_err(rx_err),
    .timeout  (rx_timeout)
  );

  pfx_state_t pfx, pfx_n;
  key_code_t  held, held_n, mapped;
  logic       push;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pfx  <= NORM;
      held <= KEY_NONE;
    end else begin
      pfx  <= pfx_n;
      held <= held_n;
    end
  end

  always_comb begin
    pfx_n  = pfx;
    held_n = held;
    push   = 1'b0;
    mapped = scan_to_key(rx_byte);
    if (rx_timeout) begin
      pfx_n = NORM;
    end else if (byte_stb) begin
      case (pfx)
        NORM: begin
          if (rx_byte == SC_BREAK)    pfx_n = BRK;
          else if (rx_byte == SC_EXT) pfx_n = EXT;
          else if (mapped != KEY_NONE && mapped != held) begin
            // A repeat of the held key is typematic and is swallowed.
            held_n = mapped;
            push   = 1'b1;
          end
        end
        BRK: begin
          if (mapped == held) held_n = KEY_NONE;
          pfx_n = NORM;
        end
        EXT:     pfx_n = (rx_byte == SC_BREAK) ? EXTBRK : NORM;
        EXTBRK:  pfx_n = NORM;
        default: pfx_n = NORM;
      endcase
    end
  end

  logic ovf_q;

`ifdef KEY_FIFO_EN
  key_code_t  mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fill;
  logic       pop, full, accept;

  assign pop    = (fill != 3'd0) && key.key_ready;
  assign full   = (fill == 3'd4);
  // A pop in the same cycle frees the slot, so push-on-full still succeeds.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= KEY_NONE;
    end else begin
      ovf_q <= push && full && !pop;
      if (accept) begin
        mem[wr_ptr] <= mapped;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (accept && !pop)      fill <= fill + 3'd1;
      else if (!accept && pop) fill <= fill - 3'd1;
    end
  end

  assign key.key_valid = (fill != 3'd0);
  assign key.key_code  = mem[rd_ptr];
`else
  logic      full_q;
  key_code_t code_q;
  logic      xfer;

  assign xfer = full_q && key.key_ready;

  // key_code is only rewritten by a push so it stays stable after a transfer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      full_q <= 1'b0;
      code_q <= KEY_NONE;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (push) begin
        if (full_q && !xfer) begin
          ovf_q <= 1'b1;
        end else begin
          code_q <= mapped;
          full_q <= 1'b1;
        end
      end else if (xfer) begin
        full_q <= 1'b0;
      end
    end
  end

  assign key.key_valid = full_q;
  assign key.key_code  = code_q;
`endif

  // Pulses are masked while reset is held so none appear in a reset cycle.
  assign frame_err = rx_err && resetn;
  assign overflow  = ovf_q && resetn;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: directed PS/2 frames, scoreboard of expected key codes.
// Latency checked from the stop-bit pin edge; error and overflow pulses counted by the monitor.
// key_ready driven by stimulus to exercise holding and dropping.
module tb_ps2_key_decoder;
  import hangman_kbd_pkg::*;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF           = 20;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic frame_err, overflow;

  ps2_key_decoder_if key ();

  ps2_key_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .key      (key),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int        n_cmp = 0;
  int        n_bad = 0;
  int        err_seen = 0;
  int        ovf_seen = 0;
  int        popped = 0;
  int        lat = -1;
  key_code_t exp_q[$];

`ifdef KEY_FIFO_EN
  localparam int FIFO_MODE = 1;
`else
  localparam int FIFO_MODE = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor samples just after the negedge, after stimulus has settled its inputs.
  key_code_t e;
  always @(negedge clk) begin
    #1;
    if (resetn) begin
      if (frame_err) err_seen++;
      if (overflow)  ovf_seen++;
      if (key.key_valid && key.key_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_key: got %0d, required none", key.key_code);
        end else begin
          e = exp_q.pop_front();
          check("key_code", 32'(key.key_code), 32'(e));
        end
      end
    end
  end

  // Sends the first nbits of an 11-bit frame; meas records cycles from the stop-bit
  // falling pin edge to key_valid.
  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input int nbits = 11, input bit meas = 1'b0);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      step(HALF / 2);
      ps2_clk = 1'b0;
      if (meas && i == 10) begin
        for (int c = 1; c <= HALF; c++) begin
          step(1);
          if (lat < 0 && key.key_valid) lat = c;
        end
      end else begin
        step(HALF);
      end
      ps2_clk = 1'b1;
      step(HALF / 2);
    end
    ps2_dat = 1'b1;
    step(2 * HALF);
  endtask

  initial begin
    key.key_ready = 1'b1;
    resetn = 1'b0;
    step(5);
    check("rst_key_valid", 32'(key.key_valid), 0);
    check("rst_key_code", 32'(key.key_code), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overflow", 32'(overflow), 0);
    resetn = 1'b1;
    step(5);

    // Make A, then break A.
    exp_q.push_back(5'd1);
    send_frame(8'h1C, 1'b0, 11, 1'b1);
    check("latency", lat, 2 + FILTER_LEN + 2);
    send_frame(8'hF0);
    send_frame(8'h1C);
    step(20);
    check("t1_popped", popped, 1);
    check("t1_err", err_seen, 0);

    // Typematic E, release, press again.
    exp_q.push_back(5'd5);
    send_frame(8'h24);
    send_frame(8'h24);
    send_frame(8'h24);
    send_frame(8'hF0);
    send_frame(8'h24);
    exp_q.push_back(5'd5);
    send_frame(8'h24);
    step(20);
    check("t2_popped", popped, 3);

    // Enter with bad parity, then Backspace.
    send_frame(8'h5A, 1'b1);
    step(20);
    check("t3_err", err_seen, 1);
    check("t3_popped", popped, 3);
    exp_q.push_back(KEY_BKSP);
    send_frame(8'h66);
    step(20);
    check("t3_popped_bksp", popped, 4);

    // Extended make/break is ignored, then Q.
    exp_q.push_back(5'd17);
    send_frame(8'hE0);
    send_frame(8'h75);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    send_frame(8'h15);
    step(20);
    check("t4_popped", popped, 5);

    // Consumer stalled while Z then Q arrive.
    key.key_ready = 1'b0;
    exp_q.push_back(5'd26);
    send_frame(8'h1A);
    if (FIFO_MODE != 0) exp_q.push_back(5'd17);
    send_frame(8'h15);
    step(20);
    check("t5_held_valid", 32'(key.key_valid), 1);
    check("t5_held_code", 32'(key.key_code), 26);
    check("t5_overflow", ovf_seen, (FIFO_MODE != 0) ? 0 : 1);
    check("t5_popped_stalled", popped, 5);
    key.key_ready = 1'b1;
    step(20);
    check("t5_popped", popped, (FIFO_MODE != 0) ? 7 : 6);

    // Truncated frame times out, reset during a partial frame, then A.
    send_frame(8'h00, 1'b0, 5);
    step(TIMEOUT_CYCLES + 100);
    check("t6_timeout_err", err_seen, 2);
    send_frame(8'h00, 1'b0, 3);
    resetn = 1'b0;
    step(3);
    check("t6_rst_valid", 32'(key.key_valid), 0);
    check("t6_rst_err", 32'(frame_err), 0);
    resetn = 1'b1;
    step(10);
    exp_q.push_back(5'd1);
    send_frame(8'h1C);
    step(20);
    check("t6_popped", popped, (FIFO_MODE != 0) ? 8 : 7);
    check("t6_err", err_seen, 2);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
